pc_stack: RTL
=============

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, program-memory address width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_ADDR, default 0, address loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cycle  input  CYCLE_WIDTH  processor cycle phase; PC updates only when cycle == CYCLE_EXEC.
REQ-007 branch  input  1  take branch to target.
REQ-008 branch_rel  input  1  target is PC-relative when 1, absolute when 0.
REQ-009 call  input  1  push return address and jump to target.
REQ-010 ret  input  1  pop return address into PC.
REQ-011 branch_addr  input  ADDR_WIDTH  absolute target or two's-complement offset.
REQ-012 addr  output  ADDR_WIDTH  current PC, registered, no combinational path from inputs.
REQ-013 stack_full  output  1  stack holds STACK_DEPTH entries.
REQ-014 stack_empty  output  1  stack holds zero entries.
REQ-015 stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-016 SHALL hold all state when cycle != CYCLE_EXEC, regardless of branch/call/ret.
REQ-017 SHALL, on exec edges, apply priority ret > call > branch > increment.
REQ-018 Increment: PC <= PC+1 modulo 2^ADDR_WIDTH (all-ones wraps to 0).
REQ-019 Branch: PC <= target; target = branch_addr (absolute) or PC+branch_addr (relative), modulo 2^ADDR_WIDTH.
REQ-020 Call: push PC+1 (wrapped), PC <= target as in REQ-019; branch_rel applies to call.
REQ-021 Ret: PC <= top entry, pop; one exec cycle latency, no bubble.
REQ-022 Call when stack_full: jump taken, push dropped, contents unchanged, stack_err <= 1.
REQ-023 Ret when stack_empty: PC <= PC+1, depth unchanged, stack_err <= 1.
REQ-024 call and ret together: ret executed, call ignored, no error.
REQ-025 stack_full/stack_empty SHALL be registered, consistent with depth on the same cycle as addr.
REQ-026 stack_err SHALL stay 1 until reset.

Reset
REQ-027 reset asserted SHALL immediately force addr = RESET_ADDR, depth = 0, stack_empty = 1, stack_full = 0, stack_err = 0, mid-cycle included.
REQ-028 Stack entry contents need not be cleared; they are unobservable while empty.
REQ-029 First update after reset deassertion occurs at the next exec edge.

Configuration
REQ-030 Macro PC_STACK_REL_BRANCH_EN defined: relative targets per REQ-019.
REQ-031 Macro undefined: branch_rel port retained but ignored; all targets absolute; no adder beyond PC+1 synthesised.

Structure
REQ-032 Shared package pc_pkg SHALL hold CYCLE_WIDTH, cycle typedef, CYCLE_EXEC constant, and pc_op_t enum {OP_INC, OP_BRANCH, OP_CALL, OP_RET}.
REQ-033 Priority decode SHALL produce a pc_op_t; one sub-module, return_stack (LIFO with push, pop, top, full, empty, parametrised by width and depth), is instantiated.

Verification
REQ-034 Reset, 5 exec cycles, ADDR_WIDTH=8 -> addr 0,1,2,3,4,5; non-exec cycles interleaved -> addr unchanged.
REQ-035 PC=0x10, call to 0x40, exec, then ret -> addr 0x40 then 0x11; stack_empty 0->... returns to 1.
REQ-036 STACK_DEPTH=4, five nested calls -> stack_full after 4th, stack_err=1 after 5th, four rets unwind correct addresses.
REQ-037 Empty stack, ret at PC=0x22 -> addr 0x23, stack_err=1, held until reset.
REQ-038 With PC_STACK_REL_BRANCH_EN, PC=0x05, relative branch offset 0xFE -> addr 0x03; PC=0xFF increment -> 0x00.
REQ-039 reset pulsed mid-cycle with depth 2 -> addr=RESET_ADDR, stack_empty=1, stack_err=0 asynchronously.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter block: cycle phase encoding and PC operation decode.
// Relative branch targets are enabled by defining PC_STACK_REL_BRANCH_EN.
package pc_pkg;

    localparam int CYCLE_WIDTH = 2;

    typedef logic [CYCLE_WIDTH-1:0] cycle_t;

    localparam cycle_t CYCLE_EXEC = 2'd2;

    typedef enum logic [1:0] {
        OP_INC,
        OP_BRANCH,
        OP_CALL,
        OP_RET
    } pc_op_t;

    // ret wins over call, which wins over branch; nothing requested means increment.
    function automatic pc_op_t decode_op(input logic branch, input logic call, input logic ret);
        if (ret) begin
            return OP_RET;
        end else if (call) begin
            return OP_CALL;
        end else if (branch) begin
            return OP_BRANCH;
        end
        return OP_INC;
    endfunction

endpackage

// File: rtl/pc_stack_return_stack.sv
// LIFO of return addresses with registered full/empty flags.
// A push while full or a pop while empty is ignored; the owner reports the error.
module return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic [IW-1:0]    wr_idx, top_idx;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;
    assign wr_idx  = cnt_q[IW-1:0];
    // At full depth the low bits wrap to zero, so minus one still lands on the last slot.
    assign top_idx = wr_idx - IW'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // Entry storage is never cleared; stale entries are unreachable below the count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_idx] <= data_i;
        end
    end

    assign top_o   = mem[top_idx];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/pc_stack.sv
// Program counter with call/return stack; advances only on the exec phase of the processor cycle.
// Define PC_STACK_REL_BRANCH_EN to make branch_rel select PC-relative targets.
module pc_stack
    import pc_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  cycle_t                cycle,
    input  logic                  branch,
    input  logic                  branch_rel,
    input  logic                  call,
    input  logic                  ret,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  stack_err
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] rs_top;
    logic                  rs_full, rs_empty;
    logic                  push, pop;
    logic                  exec;
    pc_op_t                op;

    assign exec   = (cycle == CYCLE_EXEC);
    assign op     = decode_op(branch, call, ret);
    assign pc_inc = pc_q + ADDR_WIDTH'(1);

`ifdef PC_STACK_REL_BRANCH_EN
    assign target = branch_rel ? (pc_q + branch_addr) : branch_addr;
`else
    logic unused_branch_rel;
    assign unused_branch_rel = branch_rel;
    assign target            = branch_addr;
`endif

    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        push  = 1'b0;
        pop   = 1'b0;
        if (exec) begin
            case (op)
                OP_RET: begin
                    if (rs_empty) begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end else begin
                        pc_d = rs_top;
                        pop  = 1'b1;
                    end
                end
                OP_CALL: begin
                    // The jump is taken even when the return address cannot be saved.
                    pc_d = target;
                    if (rs_full) begin
                        err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                OP_BRANCH: pc_d = target;
                default:   pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= ADDR_WIDTH'(RESET_ADDR);
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    return_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .top_o   (rs_top),
        .full_o  (rs_full),
        .empty_o (rs_empty)
    );

    assign addr        = pc_q;
    assign stack_full  = rs_full;
    assign stack_empty = rs_empty;
    assign stack_err   = err_q;

endmodule
